// File: rtl/mips_cpu_definitions.sv
// Shared CPU/bus definitions: slave handshake states, reset vector and the
// request payload captured by bus slaves while they stall the master.
package mips_cpu_definitions;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BYTE_W = DATA_W / 8;
    localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } bus_slave_state_t;

    typedef struct packed {
        logic [31:0]         address;
        logic                read;
        logic                write;
        logic [DATA_W-1:0]   writedata;
        logic [BYTE_W-1:0]   byteenable;
    } bus_req_t;

    // Word distance of a byte address from a window base; wraps below the base.
    function automatic logic [29:0] word_offset(input logic [31:0] addr, input logic [31:0] base);
        return addr[31:2] - base[31:2];
    endfunction

endpackage

// File: rtl/mips_bus_ram_slave_if.sv
// Avalon-MM style bus between the MIPS CPU (master) and a memory slave.
interface mips_bus_ram_slave_if;
    import mips_cpu_definitions::*;

    logic [31:0]       address;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic [BYTE_W-1:0] byteenable;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;
    logic              err;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata, err
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata, err
    );

endinterface

// File: rtl/mips_bus_ram_array.sv
// Word-wide RAM with per-byte write enables and an asynchronous read port.
module mips_bus_ram_array
    import mips_cpu_definitions::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter string       INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic [BYTE_W-1:0]     we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(BYTE_W); i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mips_bus_ram_slave.sv
// Avalon-MM RAM slave for the MIPS CPU: programmable wait states, address
// window decode and a sticky error flag for protocol or decode violations.
module mips_bus_ram_slave
    import mips_cpu_definitions::*;
#(
    parameter logic [31:0] BASE_ADDR   = RESET_VECTOR,
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter string       INIT_FILE   = ""
) (
    input  logic                 clk,
    input  logic                 reset,
    mips_bus_ram_slave_if.slave  bus
);

    localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 32'd0);

    bus_slave_state_t  state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    bus_req_t          lat_q, lat_d;
    logic              err_q, err_d;

    bus_req_t          live;
    bus_req_t          xfer;
    logic              do_xfer;
    logic              waitrequest;
    logic [29:0]       word_off;
    logic              in_range;
    logic              aligned;
    logic              access_ok;
    logic [BYTE_W-1:0] mem_we;
    logic [DATA_W-1:0] mem_rdata;

    assign live = '{address:    bus.address,
                    read:       bus.read,
                    write:      bus.write,
                    writedata:  bus.writedata,
                    byteenable: bus.byteenable};

    // Decode of whichever request is completing this cycle.
    assign word_off  = word_offset(xfer.address, BASE_ADDR);
    assign in_range  = (word_off >> ADDR_WIDTH) == '0;
    assign aligned   = xfer.address[1:0] == 2'b00;
    assign access_ok = in_range && aligned;

    // Handshake sequencing: accept, stall, complete or abort.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lat_d       = lat_q;
        err_d       = err_q;
        waitrequest = 1'b0;
        xfer        = live;
        do_xfer     = 1'b0;

        case (state_q)
            IDLE: begin
                if (live.read && live.write) begin
                    err_d = 1'b1;
                end else if (live.read || live.write) begin
                    if (WAIT_CYCLES == 0) begin
                        do_xfer = 1'b1;
                    end else begin
                        waitrequest = 1'b1;
                        lat_d       = live;
                        cnt_d       = CNT_LOAD;
                        state_d     = WAIT;
                    end
                end
            end
            WAIT: begin
                xfer = lat_q;
                if (live != lat_q) begin
                    err_d = 1'b1;
                end
                if (!live.read && !live.write) begin
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    waitrequest = 1'b1;
                    cnt_d       = cnt_q - CNT_W'(1);
                end else begin
                    do_xfer = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (do_xfer && !access_ok) begin
            err_d = 1'b1;
        end
    end

    // A reset landing on the completing cycle must not let the write through.
    assign mem_we = (do_xfer && xfer.write && access_ok && reset) ? xfer.byteenable : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lat_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lat_q   <= lat_d;
            err_q   <= err_d;
        end
    end

    mips_bus_ram_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .INIT_FILE  (INIT_FILE)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .addr  (word_off[ADDR_WIDTH-1:0]),
        .wdata (xfer.writedata),
        .rdata (mem_rdata)
    );

    assign bus.waitrequest = waitrequest;
    assign bus.readdata    = (do_xfer && xfer.read && access_ok) ? mem_rdata : '0;
    assign bus.err         = err_q;

endmodule

// File: tb/tb_mips_bus_ram_slave.sv
// Bench for mips_bus_ram_slave: a 2-wait-state instance and a zero-wait
// instance, checked against a word-array memory model with a sticky error bit.
module tb_mips_bus_ram_slave;
    import mips_cpu_definitions::*;

    localparam int unsigned AW    = 10;
    localparam int unsigned DEPTH = 1 << AW;
    localparam int          WAITN = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mips_bus_ram_slave_if bus();
    mips_bus_ram_slave_if bus0();

    mips_bus_ram_slave #(.BASE_ADDR(RESET_VECTOR), .ADDR_WIDTH(AW), .WAIT_CYCLES(WAITN), .INIT_FILE(""))
        dut (.clk(clk), .reset(reset), .bus(bus));
    mips_bus_ram_slave #(.BASE_ADDR(RESET_VECTOR), .ADDR_WIDTH(AW), .WAIT_CYCLES(0), .INIT_FILE(""))
        dut0 (.clk(clk), .reset(reset), .bus(bus0));

    int errors = 0;
    int checks = 0;

    logic [31:0] mem_m  [DEPTH];
    logic [31:0] mem0_m [DEPTH];

    logic [31:0] rd;
    int          st;
    bit          ok;

    function automatic bit addr_ok(input logic [31:0] a);
        logic [31:0] off;
        off = (a >> 2) - (RESET_VECTOR >> 2);
        return (a % 4 == 0) && (off < DEPTH);
    endfunction

    function automatic int unsigned addr_idx(input logic [31:0] a);
        return int'((a >> 2) - (RESET_VECTOR >> 2));
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.address = '0;  bus.read = 1'b0;  bus.write = 1'b0;  bus.writedata = '0;  bus.byteenable = '0;
        bus0.address = '0; bus0.read = 1'b0; bus0.write = 1'b0; bus0.writedata = '0; bus0.byteenable = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    // One transfer on the wait-state instance; starts and ends just after a posedge.
    task automatic bus_xfer(input bit is_rd, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [3:0] be, output logic [31:0] rdata, output int stalls,
                            output bit done);
        bus.address = addr; bus.read = is_rd; bus.write = !is_rd;
        bus.writedata = wd; bus.byteenable = be;
        stalls = 0; done = 1'b0; rdata = '0;
        for (int c = 0; c < 16 && !done; c++) begin
            @(negedge clk);
            if (bus.waitrequest === 1'b0) begin
                rdata = bus.readdata;
                done  = 1'b1;
            end else begin
                stalls++;
            end
            step();
        end
        bus.read = 1'b0; bus.write = 1'b0;
        if (done && !is_rd && addr_ok(addr)) mem_m[addr_idx(addr)] = merge(mem_m[addr_idx(addr)], wd, be);
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        repeat (2) step();
        reset = 1'b1;
        @(negedge clk);
        checks++; if (bus.waitrequest !== 1'b0) begin errors++; $display("FAIL reset_wait: got %b want 0", bus.waitrequest); end
        checks++; if (bus.readdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", bus.readdata); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus.err); end
        checks++; if (bus0.err !== 1'b0 || bus0.waitrequest !== 1'b0) begin errors++; $display("FAIL reset_zw: got err=%b wait=%b want 0/0", bus0.err, bus0.waitrequest); end
        step();
    endtask

    task automatic test_reset_vector();
        bus_xfer(1'b0, RESET_VECTOR, 32'h24020005, 4'hF, rd, st, ok);
        checks++; if (!ok || st != WAITN) begin errors++; $display("FAIL rv_write_latency: got done=%0d stalls=%0d want 1/%0d", ok, st, WAITN); end
        bus_xfer(1'b1, RESET_VECTOR, 32'h0, 4'hF, rd, st, ok);
        checks++; if (!ok || st != WAITN) begin errors++; $display("FAIL rv_read_latency: got done=%0d stalls=%0d want 1/%0d", ok, st, WAITN); end
        checks++; if (rd !== 32'h24020005) begin errors++; $display("FAIL rv_read_data: got %h want 24020005", rd); end
        @(negedge clk);
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL rv_err: got %b want 0", bus.err); end
        checks++; if (bus.readdata !== 32'h0) begin errors++; $display("FAIL rv_idle_rdata: got %h want 0", bus.readdata); end
        step();
    endtask

    task automatic test_byte_lanes();
        bus_xfer(1'b0, 32'hBFC00010, 32'h11223344, 4'hF, rd, st, ok);
        bus_xfer(1'b0, 32'hBFC00010, 32'hAABBCCDD, 4'b0101, rd, st, ok);
        bus_xfer(1'b1, 32'hBFC00010, 32'h0, 4'hF, rd, st, ok);
        checks++; if (rd !== 32'h11BB33DD) begin errors++; $display("FAIL lanes_merge: got %h want 11bb33dd", rd); end
        bus_xfer(1'b0, 32'hBFC00010, 32'hFFFFFFFF, 4'b0000, rd, st, ok);
        checks++; if (!ok || st != WAITN) begin errors++; $display("FAIL lanes_be0_latency: got done=%0d stalls=%0d want 1/%0d", ok, st, WAITN); end
        bus_xfer(1'b1, 32'hBFC00010, 32'h0, 4'hF, rd, st, ok);
        checks++; if (rd !== 32'h11BB33DD) begin errors++; $display("FAIL lanes_be0_nochange: got %h want 11bb33dd", rd); end
        @(negedge clk);
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL lanes_err: got %b want 0", bus.err); end
        step();
    endtask

    task automatic test_random_traffic();
        logic [31:0] a;
        bit          is_rd;
        for (int i = 0; i < 16; i++) bus_xfer(1'b0, RESET_VECTOR + 32'(4*i), $urandom, 4'hF, rd, st, ok);
        for (int n = 0; n < 40; n++) begin
            a     = RESET_VECTOR + 32'(4 * $urandom_range(0, 15));
            is_rd = $urandom_range(0, 1) == 1;
            bus_xfer(is_rd, a, $urandom, 4'($urandom), rd, st, ok);
            checks++; if (!ok || st != WAITN) begin errors++; $display("FAIL rand_latency[%0d]: got done=%0d stalls=%0d want 1/%0d", n, ok, st, WAITN); end
            if (is_rd) begin
                checks++; if (rd !== mem_m[addr_idx(a)]) begin errors++; $display("FAIL rand_read[%0d] @%h: got %h want %h", n, a, rd, mem_m[addr_idx(a)]); end
            end
        end
        @(negedge clk);
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL rand_err: got %b want 0", bus.err); end
        step();
    endtask

    task automatic test_zero_wait();
        logic [31:0] a, d, exp;
        bit          rdop;
        for (int i = 0; i < 4; i++) begin
            a    = (i < 2) ? 32'hBFC00040 : 32'hBFC00044;
            rdop = (i % 2) == 1;
            d    = $urandom;
            bus0.address = a; bus0.read = rdop; bus0.write = !rdop;
            bus0.writedata = d; bus0.byteenable = 4'hF;
            exp = rdop ? mem0_m[addr_idx(a)] : 32'h0;
            @(negedge clk);
            checks++; if (bus0.waitrequest !== 1'b0) begin errors++; $display("FAIL zw_wait[%0d]: got %b want 0", i, bus0.waitrequest); end
            checks++; if (bus0.readdata !== exp) begin errors++; $display("FAIL zw_rdata[%0d]: got %h want %h", i, bus0.readdata, exp); end
            if (!rdop) mem0_m[addr_idx(a)] = d;
            step();
        end
        bus0.read = 1'b0; bus0.write = 1'b0;
        @(negedge clk);
        checks++; if (bus0.err !== 1'b0) begin errors++; $display("FAIL zw_err: got %b want 0", bus0.err); end
        step();
    endtask

    task automatic test_out_of_range();
        bus_xfer(1'b1, 32'h00000000, 32'h0, 4'hF, rd, st, ok);
        checks++; if (!ok || st != WAITN) begin errors++; $display("FAIL oor_latency: got done=%0d stalls=%0d want 1/%0d", ok, st, WAITN); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL oor_rdata: got %h want 0", rd); end
        @(negedge clk);
        checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL oor_err_set: got %b want 1", bus.err); end
        step();
        bus_xfer(1'b0, RESET_VECTOR + 32'h1000, 32'hDEADBEEF, 4'hF, rd, st, ok);
        repeat (4) step();
        bus_xfer(1'b1, RESET_VECTOR, 32'h0, 4'hF, rd, st, ok);
        checks++; if (rd !== mem_m[0]) begin errors++; $display("FAIL oor_write_dropped: got %h want %h", rd, mem_m[0]); end
        @(negedge clk);
        checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL oor_err_sticky: got %b want 1", bus.err); end
        step();
        apply_reset();
        @(negedge clk);
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL oor_err_cleared: got %b want 0", bus.err); end
        step();
    endtask

    task automatic test_protocol();
        bus.address = RESET_VECTOR; bus.read = 1'b1; bus.write = 1'b1;
        bus.writedata = 32'hFFFFFFFF; bus.byteenable = 4'hF;
        @(negedge clk);
        checks++; if (bus.waitrequest !== 1'b0 || bus.readdata !== 32'h0) begin errors++; $display("FAIL rw_both_resp: got wait=%b rdata=%h want 0/0", bus.waitrequest, bus.readdata); end
        step();
        bus.read = 1'b0; bus.write = 1'b0;
        @(negedge clk);
        checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL rw_both_err: got %b want 1", bus.err); end
        step();
        bus_xfer(1'b1, RESET_VECTOR, 32'h0, 4'hF, rd, st, ok);
        checks++; if (rd !== mem_m[0]) begin errors++; $display("FAIL rw_both_nochange: got %h want %h", rd, mem_m[0]); end
        apply_reset();
        bus_xfer(1'b1, 32'hBFC00002, 32'h0, 4'hF, rd, st, ok);
        checks++; if (!ok || st != WAITN || rd !== 32'h0) begin errors++; $display("FAIL misaligned_read: got done=%0d stalls=%0d rdata=%h want 1/%0d/0", ok, st, rd, WAITN); end
        @(negedge clk);
        checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL misaligned_err: got %b want 1", bus.err); end
        step();
        bus_xfer(1'b0, 32'hBFC00006, 32'h5A5A5A5A, 4'hF, rd, st, ok);
        bus_xfer(1'b1, 32'hBFC00004, 32'h0, 4'hF, rd, st, ok);
        checks++; if (rd !== mem_m[1]) begin errors++; $display("FAIL misaligned_write_dropped: got %h want %h", rd, mem_m[1]); end
        apply_reset();
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] old;
        old = mem_m[8];
        bus.read = 1'b1; bus.write = 1'b1;
        step();
        bus.address = 32'hBFC00020; bus.read = 1'b0; bus.write = 1'b1;
        bus.writedata = ~old; bus.byteenable = 4'hF;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++; if (bus.waitrequest !== 1'b1) begin errors++; $display("FAIL midrst_stall[%0d]: got %b want 1", c, bus.waitrequest); end
            step();
        end
        reset = 1'b0;
        step();
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        checks++; if (bus.waitrequest !== 1'b0 || bus.err !== 1'b0) begin errors++; $display("FAIL midrst_after: got wait=%b err=%b want 0/0", bus.waitrequest, bus.err); end
        step();
        bus_xfer(1'b1, 32'hBFC00020, 32'h0, 4'hF, rd, st, ok);
        checks++; if (st != WAITN) begin errors++; $display("FAIL midrst_fresh_latency: got %0d want %0d", st, WAITN); end
        checks++; if (rd !== old) begin errors++; $display("FAIL midrst_nowrite: got %h want %h", rd, old); end
    endtask

    task automatic test_abort_and_change();
        bus.address = 32'hBFC00024; bus.read = 1'b0; bus.write = 1'b1;
        bus.writedata = ~mem_m[9]; bus.byteenable = 4'hF;
        step();
        bus.write = 1'b0;
        @(negedge clk);
        checks++; if (bus.waitrequest !== 1'b0) begin errors++; $display("FAIL abort_wait: got %b want 0", bus.waitrequest); end
        step();
        @(negedge clk);
        checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL abort_err: got %b want 1", bus.err); end
        step();
        bus_xfer(1'b1, 32'hBFC00024, 32'h0, 4'hF, rd, st, ok);
        checks++; if (rd !== mem_m[9]) begin errors++; $display("FAIL abort_nowrite: got %h want %h", rd, mem_m[9]); end
        apply_reset();
        bus.address = 32'hBFC00028; bus.read = 1'b1; bus.write = 1'b0;
        bus.writedata = '0; bus.byteenable = 4'hF;
        step();
        bus.address = 32'hBFC0002C;
        @(negedge clk);
        checks++; if (bus.waitrequest !== 1'b1 || bus.readdata !== 32'h0) begin errors++; $display("FAIL change_stall: got wait=%b rdata=%h want 1/0", bus.waitrequest, bus.readdata); end
        step();
        @(negedge clk);
        checks++; if (bus.waitrequest !== 1'b0 || bus.readdata !== mem_m[10]) begin errors++; $display("FAIL change_latched: got wait=%b rdata=%h want 0/%h", bus.waitrequest, bus.readdata, mem_m[10]); end
        step();
        idle_inputs();
        @(negedge clk);
        checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL change_err: got %b want 1", bus.err); end
        step();
        apply_reset();
    endtask

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            mem_m[i]  = 32'h0;
            mem0_m[i] = 32'h0;
        end
        test_reset();
        test_reset_vector();
        test_byte_lanes();
        test_random_traffic();
        test_zero_wait();
        test_out_of_range();
        test_protocol();
        test_reset_mid_wait();
        test_abort_and_change();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
